// File: rtl/uwb_pkg.sv
// Shared types and defaults for the UWB poll/burst reader.
package uwb_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_POLL_LEN,
    S_POLL_CMD,
    S_POLL_DUMMY,
    S_POLL_WAIT,
    S_DECIDE,
    S_GAP,
    S_BURST_LEN,
    S_BURST_CMD,
    S_BURST_DATA,
    S_DRAIN
  } state_t;

  localparam int UWB_STAT_CMD  = 3;
  localparam int UWB_BURST_CMD = 191;

  // Per-slot tag travelling alongside the SPI response latency.
  typedef struct packed {
    logic valid;
    logic last;
    logic hdr;
  } slot_tag_t;

  // SPI frame length byte: payload slots plus the command slot.
  function automatic logic [15:0] frame_len(input logic [15:0] payload);
    return payload + 16'd1;
  endfunction

endpackage

// File: rtl/uwb_burst_reader_if.sv
// Downstream byte stream towards the FTDI TX FIFO; ready is advisory only.
interface uwb_burst_reader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/uwb_rx_align.sv
// Delays per-slot tags by RX_LAT cycles so they line up with the SPI response bytes.
module uwb_rx_align
  import uwb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RX_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  slot_tag_t         slot_tag,
  input  logic [DATA_W-1:0] hdr_data,
  input  logic [DATA_W-1:0] rx_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [DATA_W-1:0] out_data
);

  slot_tag_t pipe [RX_LAT];
  slot_tag_t tag_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RX_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= slot_tag;
      for (int i = 1; i < RX_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out   = pipe[RX_LAT-1];
  assign out_valid = tag_out.valid | tag_out.hdr;
  assign out_last  = tag_out.valid & tag_out.last;
  assign out_data  = tag_out.hdr   ? hdr_data :
                     tag_out.valid ? rx_data  : '0;

endmodule

// File: rtl/uwb_burst_reader.sv
// Polls UWB TX-buffer usage over the byte-slot SPI master and burst-reads it into the FTDI FIFO.
// Define UWB_RD_HDR_EN to prefix each burst with a length header byte.
module uwb_burst_reader
  import uwb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int MAX_BURST = 64,
  parameter int RX_LAT    = 2,
  parameter int STAT_CMD  = UWB_STAT_CMD,
  parameter int BURST_CMD = UWB_BURST_CMD,
  parameter int POLL_GAP  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CNT_W-1:0]    fifo_free,
  output logic [DATA_W-1:0]   spi_tx_data,
  input  logic [DATA_W-1:0]   spi_rx_data,
  uwb_burst_reader_if.master  out_if,
  output logic                busy,
  output logic                overflow,
  input  logic                clr_ovf
);

  // state        | meaning
  // S_IDLE       | spi idle, waits for en
  // S_POLL_LEN   | poll frame length byte (2)
  // S_POLL_CMD   | usage-query command
  // S_POLL_DUMMY | dummy slot whose response is the usage
  // S_POLL_WAIT  | RX_LAT cycles until usage arrives, captured on last
  // S_DECIDE     | n = min(usage, MAX_BURST, free space)
  // S_GAP        | POLL_GAP idle cycles after an empty poll
  // S_BURST_LEN  | burst frame length byte (n+1)
  // S_BURST_CMD  | burst-read command
  // S_BURST_DATA | n dummy slots, each returns one data byte
  // S_DRAIN      | RX_LAT cycles for the last responses to land

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [CNT_W-1:0] MAX_B  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RX_LAT - 1);
  localparam logic [GAP_W-1:0] GAP_M1 = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  tmr, tmr_nxt;
  logic [CNT_W-1:0]  n, n_nxt;
  logic [CNT_W-1:0]  u, u_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [CNT_W-1:0]  cap, n_calc;
  slot_tag_t         slot_tag;
  logic              out_valid_i, out_last_i;
  logic [DATA_W-1:0] out_data_i;

  always_comb begin
`ifdef UWB_RD_HDR_EN
    // One FIFO entry is reserved for the header byte.
    cap = (fifo_free == '0) ? '0 : fifo_free - CNT_W'(1);
`else
    cap = fifo_free;
`endif
    n_calc = (u < MAX_B) ? u : MAX_B;
    if (cap < n_calc) n_calc = cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tmr     <= '0;
      n       <= '0;
      u       <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      n       <= n_nxt;
      u       <= u_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    n_nxt       = n;
    u_nxt       = u;
    gap_nxt     = gap_cnt;
    spi_tx_data = '0;
    slot_tag    = '0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE:       if (en) state_nxt = S_POLL_LEN;
      S_POLL_LEN: begin
        spi_tx_data = DATA_W'(2);
        state_nxt   = S_POLL_CMD;
      end
      S_POLL_CMD: begin
        spi_tx_data = DATA_W'(STAT_CMD);
        state_nxt   = S_POLL_DUMMY;
      end
      S_POLL_DUMMY: begin
        tmr_nxt   = LAT_M1;
        state_nxt = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (tmr == '0) begin
          u_nxt     = CNT_W'(spi_rx_data);
          state_nxt = S_DECIDE;
        end else begin
          tmr_nxt = tmr - CNT_W'(1);
        end
      end
      S_DECIDE: begin
        n_nxt = n_calc;
        if (n_calc != '0) begin
          state_nxt = S_BURST_LEN;
        end else if (POLL_GAP == 0) begin
          state_nxt = S_IDLE;
        end else begin
          gap_nxt   = GAP_M1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = S_IDLE;
        else               gap_nxt   = gap_cnt - GAP_W'(1);
      end
      S_BURST_LEN: begin
        spi_tx_data = DATA_W'(frame_len(16'(n)));
        state_nxt   = S_BURST_CMD;
      end
      S_BURST_CMD: begin
        spi_tx_data = DATA_W'(BURST_CMD);
`ifdef UWB_RD_HDR_EN
        slot_tag.hdr = 1'b1;
`endif
        tmr_nxt   = n - CNT_W'(1);
        state_nxt = S_BURST_DATA;
      end
      S_BURST_DATA: begin
        slot_tag.valid = 1'b1;
        if (tmr == '0) begin
          slot_tag.last = 1'b1;
          tmr_nxt       = LAT_M1;
          state_nxt     = S_DRAIN;
        end else begin
          tmr_nxt = tmr - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (tmr == '0) state_nxt = S_IDLE;
        else           tmr_nxt   = tmr - CNT_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  uwb_rx_align #(
    .DATA_W (DATA_W),
    .RX_LAT (RX_LAT)
  ) u_rx_align (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_tag  (slot_tag),
    .hdr_data  (DATA_W'(n)),
    .rx_data   (spi_rx_data),
    .out_valid (out_valid_i),
    .out_last  (out_last_i),
    .out_data  (out_data_i)
  );

  assign out_if.out_valid = out_valid_i;
  assign out_if.out_last  = out_last_i;
  assign out_if.out_data  = out_data_i;

  // A new loss takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                overflow <= 1'b0;
    else if (out_valid_i && !out_if.out_ready) overflow <= 1'b1;
    else if (clr_ovf)                          overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uwb_burst_reader.sv
// Scoreboard bench for uwb_burst_reader with a small SPI slave model of the UWB device.
module tb_uwb_burst_reader;
  import uwb_pkg::*;

  localparam int RX_LAT   = 2;
  localparam int POLL_GAP = 16;
`ifdef UWB_RD_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  // Zero slots from the poll dummy up to the next poll: dummy, wait, decide, gap, idle.
  localparam int GAP_ZEROS = 1 + RX_LAT + 1 + POLL_GAP + 1;

  logic       clk = 1'b0;
  logic       rst_n, en, clr_ovf;
  logic [7:0] fifo_free, spi_tx_data;
  logic [7:0] spi_rx_data = 8'h00;
  logic       busy, overflow;

  uwb_burst_reader_if #(.DATA_W(8)) out_if ();

  uwb_burst_reader #(
    .DATA_W(8), .CNT_W(8), .MAX_BURST(64), .RX_LAT(RX_LAT),
    .STAT_CMD(3), .BURST_CMD(191), .POLL_GAP(POLL_GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .fifo_free   (fifo_free),
    .spi_tx_data (spi_tx_data),
    .spi_rx_data (spi_rx_data),
    .out_if      (out_if),
    .busy        (busy),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // UWB device model: answers the dummy slot of a poll with usage, burst dummies with data.
  logic [7:0] usage = 8'h00;
  logic [7:0] data_base = 8'h00;
  int         fr_len = 0, fr_rem = 0, fr_k;
  logic [7:0] fr_cmd = 8'h00;
  logic [7:0] model_r;
  logic [7:0] rx_q[$];

  initial for (int i = 0; i < RX_LAT; i++) rx_q.push_back(8'h00);

  always @(negedge clk) begin
    model_r = 8'h00;
    if (!rst_n) begin
      fr_rem = 0;
    end else if (fr_rem == 0) begin
      if (spi_tx_data != 8'h00) begin
        fr_len = int'(spi_tx_data);
        fr_rem = fr_len;
      end
    end else begin
      fr_k = fr_len - fr_rem;
      if (fr_k == 0)             fr_cmd  = spi_tx_data;
      else if (fr_cmd == 8'd3)   model_r = usage;
      else if (fr_cmd == 8'd191) model_r = data_base + 8'(fr_k - 1);
      fr_rem--;
    end
    rx_q.push_back(model_r);
  end

  always @(posedge clk) begin
    #1;
    if (rx_q.size() > 0) spi_rx_data = rx_q.pop_front();
  end

  // Monitor: every presented byte is checked against the scoreboard queue.
  int   first_cyc = 0;
  bit   first_seen = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && out_if.out_valid) begin
      if (!first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL out_unexpected: got data=%0h last=%0b, want no byte", out_if.out_data, out_if.out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_if.out_data !== mon_e.data || out_if.out_last !== mon_e.last) begin
          n_mis++;
          $display("FAIL out_byte: got data=%0h last=%0b, want data=%0h last=%0b",
                   out_if.out_data, out_if.out_last, mon_e.data, mon_e.last);
        end
      end
    end
  end

  task automatic push_burst(input int n, input logic [7:0] base);
    exp_t e;
    if (HDR != 0) begin
      e.data = 8'(n);
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      e.data = base + 8'(k);
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_tx(input logic [7:0] v, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (spi_tx_data == v) hit = 1'b1;
    end
    check(name, 32'(hit), 32'd1);
  endtask

  task automatic expect_next(input logic [7:0] v, input string name);
    @(negedge clk);
    check(name, 32'(spi_tx_data), 32'(v));
  endtask

  task automatic count_zeros(input string name);
    int z = 0;
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (spi_tx_data == 8'h00) z++;
      else                      done = 1'b1;
    end
    check(name, 32'(z), 32'(GAP_ZEROS));
    check({name, "_next"}, 32'(spi_tx_data), 32'd2);
  endtask

  task automatic idle_wait(input string name);
    repeat (40) @(negedge clk);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  int data_cyc, k_gap, n_cap, n_h;
  bit done;

  initial begin
    rst_n = 1'b0; en = 1'b0; clr_ovf = 1'b0; fifo_free = 8'd100;
    out_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_spi_tx", 32'(spi_tx_data), 32'd0);
    check("rst_valid", 32'(out_if.out_valid), 32'd0);
    check("rst_last", 32'(out_if.out_last), 32'd0);
    check("rst_data", 32'(out_if.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_en", 32'(busy), 32'd0);

    // Normal burst: usage 5, data 0x11..0x15.
    usage = 8'd5; data_base = 8'h11;
    push_burst(5, 8'h11);
    first_seen = 1'b0;
    en = 1'b1;
    wait_tx(8'd2, "poll_len");
    expect_next(8'd3, "poll_cmd");
    expect_next(8'd0, "poll_dummy");
    wait_tx(8'd6, "burst_len");
    en = 1'b0;
    expect_next(8'd191, "burst_cmd");
    @(negedge clk);
    data_cyc = cyc;
    check("burst_dummy0", 32'(spi_tx_data), 32'd0);
    for (int i = 1; i < 5; i++) expect_next(8'd0, "burst_dummy");
    idle_wait("normal");
    check("first_valid_lat", 32'(first_cyc - data_cyc), 32'(RX_LAT - HDR));

    // Caps: fifo_free limits the burst, next poll follows without a gap.
    n_cap = (HDR != 0) ? 9 : 10;
    usage = 8'd200; fifo_free = 8'd10; data_base = 8'h40;
    push_burst(n_cap, 8'h40);
    en = 1'b1;
    wait_tx(8'(n_cap + 1), "cap_len");
    usage = 8'd0;
    expect_next(8'd191, "cap_cmd");
    k_gap = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      k_gap++;
      if (spi_tx_data != 8'h00) done = 1'b1;
    end
    check("cap_no_gap", 32'(k_gap), 32'(n_cap + RX_LAT + 2));
    check("cap_next_poll", 32'(spi_tx_data), 32'd2);

    // Empty poll: usage 0 takes the gap path.
    expect_next(8'd3, "gap_poll_cmd");
    count_zeros("gap_len");
    en = 1'b0;
    idle_wait("gap");

    // fifo_free = 0 forces n = 0 despite usage.
    usage = 8'd5; fifo_free = 8'd0;
    en = 1'b1;
    wait_tx(8'd2, "ff0_poll");
    expect_next(8'd3, "ff0_cmd");
    count_zeros("ff0_gap");
    en = 1'b0;
    idle_wait("ff0");
    fifo_free = 8'd100;

    // Overflow: backpressure on the 3rd data byte.
    usage = 8'd5; data_base = 8'h20;
    push_burst(5, 8'h20);
    en = 1'b1;
    wait_tx(8'd6, "ovf_len");
    en = 1'b0;
    expect_next(8'd191, "ovf_cmd");
    repeat (RX_LAT + 3) @(posedge clk);
    #1 out_if.out_ready = 1'b0;
    @(negedge clk);
    check("ovf_pre", 32'(overflow), 32'd0);
    @(posedge clk);
    #1 out_if.out_ready = 1'b1;
    @(negedge clk);
    check("ovf_set", 32'(overflow), 32'd1);
    idle_wait("ovf");
    check("ovf_hold", 32'(overflow), 32'd1);
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    check("ovf_clr", 32'(overflow), 32'd0);

    // Clear and a new loss in the same cycle: set wins.
    usage = 8'd3; data_base = 8'h30;
    push_burst(3, 8'h30);
    en = 1'b1;
    wait_tx(8'd4, "ovf2_len");
    en = 1'b0;
    expect_next(8'd191, "ovf2_cmd");
    repeat (RX_LAT + 1) @(posedge clk);
    #1 out_if.out_ready = 1'b0;
    @(negedge clk);
    check("ovf2_pre", 32'(overflow), 32'd0);
    @(posedge clk);
    #1 clr_ovf = 1'b1;
    @(negedge clk);
    check("ovf2_set", 32'(overflow), 32'd1);
    @(posedge clk);
    #1 begin out_if.out_ready = 1'b1; clr_ovf = 1'b0; end
    @(negedge clk);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    idle_wait("ovf2");
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    check("ovf_clr2", 32'(overflow), 32'd0);

    // Small burst: usage 3, fifo_free 3 (header build reserves one entry).
    n_h = (HDR != 0) ? 2 : 3;
    usage = 8'd3; fifo_free = 8'd3; data_base = 8'h60;
    push_burst(n_h, 8'h60);
    en = 1'b1;
    wait_tx(8'd2, "small_poll");
    expect_next(8'd3, "small_cmd");
    wait_tx(8'(n_h + 1), "small_len");
    en = 1'b0;
    idle_wait("small");
    fifo_free = 8'd100;

    // Reset mid-burst after two data slots.
    usage = 8'd5; data_base = 8'h50;
    if (HDR != 0) push_burst(0, 8'h00);
    if (HDR != 0) begin
      exp_q.delete();
      mon_e.data = 8'd5; mon_e.last = 1'b0;
      exp_q.push_back(mon_e);
    end
    en = 1'b1;
    wait_tx(8'd6, "rstm_len");
    expect_next(8'd191, "rstm_cmd");
    expect_next(8'd0, "rstm_d0");
    expect_next(8'd0, "rstm_d1");
    check("rstm_busy_pre", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstm_spi_tx", 32'(spi_tx_data), 32'd0);
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_valid", 32'(out_if.out_valid), 32'd0);
    check("rstm_last", 32'(out_if.out_last), 32'd0);
    check("rstm_data", 32'(out_if.out_data), 32'd0);
    check("rstm_ovf", 32'(overflow), 32'd0);
    usage = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_next(8'd2, "rstm_poll_len");
    expect_next(8'd3, "rstm_poll_cmd");
    expect_next(8'd0, "rstm_poll_dummy");
    en = 1'b0;
    idle_wait("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
